// File: rtl/cl_pkg.sv
// -----------------------------------------------------------------------------
// cl_pkg
// Shared definitions for the Camera Link line packer:
//   - capture FSM state encoding
//   - default pixel and line geometry
//   - line-memory bank encoding (value of iMEM_SEL / latched bank)
// -----------------------------------------------------------------------------
package cl_pkg;

  localparam int CL_PIXEL_WIDTH = 8;
  localparam int CL_LINE_WIDTH  = 640;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    CAPTURE   = 2'd2,
    COMMIT    = 2'd3
  } cl_state_e;

endpackage : cl_pkg

// File: rtl/cl_edge_det.sv
// -----------------------------------------------------------------------------
// cl_edge_det
// Registered rise/fall detector. The input is compared with its one-cycle
// registered copy; rise/fall are combinational from the live input, so the
// edge is reported in the same cycle the new level is presented.
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous active-high reset (clears the delay register)
//   d_i     in   level to monitor
//   rise_o  out  d_i = 1 and previous = 0
//   fall_o  out  d_i = 0 and previous = 1
// -----------------------------------------------------------------------------
module cl_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule : cl_edge_det

// File: rtl/cl_line_packer.sv
// -----------------------------------------------------------------------------
// cl_line_packer
// Camera Link line capture: takes TAPS pixels per clock, builds a dark-pixel
// binary line and PLANES MSB bit-plane lines per video row, and commits each
// finished row to line-memory bank A or B with a one-cycle write strobe.
//
// Optional feature (macro CL_DARK_COUNT_EN): adds oDARK_COUNT, the number of
// in-range dark pixels of the current line, valid during the commit cycle.
//
// Ports:
//   CCLK         in   pixel clock
//   RST          in   asynchronous active-high reset
//   iVSYNC       in   frame valid
//   iDE          in   line valid
//   iDATA        in   TAPS pixels, tap k at [k*PIXEL_WIDTH +: PIXEL_WIDTH], tap 0 leftmost
//   iTHRESHOLD   in   dark threshold (pixel < threshold is dark)
//   iMEM_SEL     in   bank select, sampled at line start (0 = A, 1 = B)
//   oWE_A/oWE_B  out  one-cycle commit strobes
//   oROW         out  row being captured/committed
//   oBIN_LINE    out  bit c = 1 if pixel c is dark
//   oPLANE_LINE  out  plane p (0 = pixel MSB) at [p*LINE_WIDTH +: LINE_WIDTH]
//   oOVERFLOW    out  sticky per frame: column or row overflow
//   oDARK_COUNT  out  dark pixel count (CL_DARK_COUNT_EN only)
// -----------------------------------------------------------------------------
module cl_line_packer
  import cl_pkg::*;
#(
  parameter int PIXEL_WIDTH = CL_PIXEL_WIDTH,
  parameter int TAPS        = 2,
  parameter int LINE_WIDTH  = CL_LINE_WIDTH,
  parameter int ADDR_WIDTH  = 11,
  parameter int PLANES      = 5
) (
  input  logic                          CCLK,
  input  logic                          RST,
  input  logic                          iVSYNC,
  input  logic                          iDE,
  input  logic [TAPS*PIXEL_WIDTH-1:0]   iDATA,
  input  logic [PIXEL_WIDTH-1:0]        iTHRESHOLD,
  input  logic                          iMEM_SEL,
  output logic                          oWE_A,
  output logic                          oWE_B,
  output logic [ADDR_WIDTH-1:0]         oROW,
  output logic [LINE_WIDTH-1:0]         oBIN_LINE,
  output logic [PLANES*LINE_WIDTH-1:0]  oPLANE_LINE,
  output logic                          oOVERFLOW
`ifdef CL_DARK_COUNT_EN
  ,
  output logic [$clog2(LINE_WIDTH+1)-1:0] oDARK_COUNT
`endif
);

  localparam int COL_W  = $clog2(LINE_WIDTH + TAPS + 1);
  localparam int BIDX_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int PIDX_W = (PLANES * LINE_WIDTH > 1) ? $clog2(PLANES * LINE_WIDTH) : 1;
  localparam int DC_W   = $clog2(LINE_WIDTH + 1);

  localparam logic [COL_W-1:0]      TAPS_C  = COL_W'(TAPS);
  localparam logic [COL_W-1:0]      LINE_C  = COL_W'(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ROW_MAX = '1;

  logic de_rise, de_fall, vs_rise, vs_fall;

  cl_edge_det u_de_edge (
    .clk_i  (CCLK),
    .rst_i  (RST),
    .d_i    (iDE),
    .rise_o (de_rise),
    .fall_o (de_fall)
  );

  cl_edge_det u_vs_edge (
    .clk_i  (CCLK),
    .rst_i  (RST),
    .d_i    (iVSYNC),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  cl_state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]       row_q, row_d;
  logic [COL_W-1:0]            col_q, col_d, col_base;
  logic                        bank_q, bank_d;
  logic                        ovf_q, ovf_d;
  // Set once the maximum row has been committed; later lines of the frame
  // are still captured but never strobed.
  logic                        sat_q, sat_d;
  logic [LINE_WIDTH-1:0]       bin_q, bin_d;
  logic [PLANES*LINE_WIDTH-1:0] plane_q, plane_d;
  logic [DC_W-1:0]             dark_q, dark_d;
  logic                        start_line, do_beat;
  logic [PIXEL_WIDTH-1:0]      pix;
  int                          idx;

  // NOTE: every variable written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    bank_d     = bank_q;
    ovf_d      = ovf_q;
    sat_d      = sat_q;
    start_line = 1'b0;
    do_beat    = 1'b0;
    pix        = '0;
    idx        = 0;

    unique case (state_q)
      IDLE: begin
        if (vs_rise) begin
          row_d      = '0;
          ovf_d      = 1'b0;
          sat_d      = 1'b0;
          state_d    = WAIT_LINE;
          start_line = de_rise;
        end
      end
      WAIT_LINE: begin
        if (vs_fall)                state_d    = IDLE;
        else if (de_rise && iVSYNC) start_line = 1'b1;
      end
      CAPTURE: begin
        if (vs_fall) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          row_d   = '0;
          ovf_d   = 1'b0;
          sat_d   = 1'b0;
          state_d = WAIT_LINE;
        end else if (de_fall) begin
          state_d = COMMIT;
        end else if (iDE) begin
          do_beat = 1'b1;
        end
      end
      COMMIT: begin
        if (row_q == ROW_MAX) begin
          ovf_d = 1'b1;
          sat_d = 1'b1;
        end else begin
          row_d = row_q + ADDR_WIDTH'(1);
        end
        // The commit always completes; a VSYNC drop seen meanwhile is honoured
        // by the level check, since its edge has already gone by.
        if (!iVSYNC)      state_d    = IDLE;
        else if (de_rise) start_line = 1'b1;
        else              state_d    = WAIT_LINE;
      end
      default: state_d = IDLE;
    endcase

    if (start_line) begin
      bank_d  = iMEM_SEL;
      state_d = CAPTURE;
      do_beat = 1'b1;
    end

    // A new line starts from a cleared image so short lines read 0 beyond
    // their last written column.
    col_base = start_line ? '0 : col_q;
    col_d    = col_base;
    bin_d    = start_line ? '0 : bin_q;
    plane_d  = start_line ? '0 : plane_q;
    dark_d   = start_line ? '0 : dark_q;

    if (do_beat) begin
      for (int k = 0; k < TAPS; k++) begin
        pix = iDATA[k*PIXEL_WIDTH +: PIXEL_WIDTH];
        idx = int'(col_base) + k;
        if (idx < LINE_WIDTH) begin
          bin_d[BIDX_W'(idx)] = (pix < iTHRESHOLD);
          for (int p = 0; p < PLANES; p++) begin
            plane_d[PIDX_W'(p*LINE_WIDTH + idx)] = pix[PIXEL_WIDTH-1-p];
          end
          if (pix < iTHRESHOLD) dark_d = dark_d + DC_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      // TAPS divides LINE_WIDTH, so saturation lands exactly on LINE_WIDTH.
      col_d = (col_base >= LINE_C - TAPS_C) ? LINE_C : col_base + TAPS_C;
    end
  end

  // NOTE: the line images are plain flops, not RAM, so they take the async
  // reset like every other register and read 0 straight out of reset.
  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      bank_q  <= BANK_A;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
      bin_q   <= '0;
      plane_q <= '0;
      dark_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bank_q  <= bank_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
      bin_q   <= bin_d;
      plane_q <= plane_d;
      dark_q  <= dark_d;
    end
  end

  // Strobes decode from registered state only; the bank bit makes them
  // mutually exclusive.
  assign oWE_A       = (state_q == COMMIT) && !sat_q && (bank_q == BANK_A);
  assign oWE_B       = (state_q == COMMIT) && !sat_q && (bank_q == BANK_B);
  assign oROW        = row_q;
  assign oBIN_LINE   = bin_q;
  assign oPLANE_LINE = plane_q;
  assign oOVERFLOW   = ovf_q;

`ifdef CL_DARK_COUNT_EN
  assign oDARK_COUNT = dark_q;
`else
  // Count register is unused in this build; synthesis trims it.
  logic unused_dark;
  assign unused_dark = ^dark_q;
`endif

endmodule : cl_line_packer

// File: tb/tb_cl_line_packer.sv
// -----------------------------------------------------------------------------
// tb_cl_line_packer
// Directed self-checking bench for cl_line_packer (TAPS = 2, LINE_WIDTH = 640).
// Inputs change 1 time unit after the rising edge; outputs are checked at the
// same point, i.e. after the edge that consumed the previous inputs.
// -----------------------------------------------------------------------------
module tb_cl_line_packer;

  localparam int PW = 8;
  localparam int TP = 2;
  localparam int LW = 640;
  localparam int AW = 11;
  localparam int PL = 5;

  logic                CCLK;
  logic                RST;
  logic                iVSYNC;
  logic                iDE;
  logic [TP*PW-1:0]    iDATA;
  logic [PW-1:0]       iTHRESHOLD;
  logic                iMEM_SEL;
  logic                oWE_A;
  logic                oWE_B;
  logic [AW-1:0]       oROW;
  logic [LW-1:0]       oBIN_LINE;
  logic [PL*LW-1:0]    oPLANE_LINE;
  logic                oOVERFLOW;
`ifdef CL_DARK_COUNT_EN
  logic [$clog2(LW+1)-1:0] oDARK_COUNT;
`endif

  cl_line_packer #(
    .PIXEL_WIDTH (PW),
    .TAPS        (TP),
    .LINE_WIDTH  (LW),
    .ADDR_WIDTH  (AW),
    .PLANES      (PL)
  ) dut (
    .CCLK        (CCLK),
    .RST         (RST),
    .iVSYNC      (iVSYNC),
    .iDE         (iDE),
    .iDATA       (iDATA),
    .iTHRESHOLD  (iTHRESHOLD),
    .iMEM_SEL    (iMEM_SEL),
    .oWE_A       (oWE_A),
    .oWE_B       (oWE_B),
    .oROW        (oROW),
    .oBIN_LINE   (oBIN_LINE),
    .oPLANE_LINE (oPLANE_LINE),
    .oOVERFLOW   (oOVERFLOW)
`ifdef CL_DARK_COUNT_EN
    ,
    .oDARK_COUNT (oDARK_COUNT)
`endif
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  int checks = 0;
  int errors = 0;

  // Expected line image, built from the pixels the bench drives.
  logic [LW-1:0]    m_bin;
  logic [PL*LW-1:0] m_plane;
  int               m_col;
  logic [LW-1:0]    exp_bin;
  logic [LW-1:0]    exp_p0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [PL*LW-1:0] obs,
                       input logic [PL*LW-1:0] exp);
    int first;
    checks++;
    assert (obs === exp) else begin
      errors++;
      first = -1;
      for (int i = PL*LW-1; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
      $error("FAIL %s first differing bit %0d observed=%b expected=%b",
             tag, first, obs[first], exp[first]);
    end
  endtask

  task automatic model_start;
    m_bin   = '0;
    m_plane = '0;
    m_col   = 0;
  endtask

  // One capture beat: tap 0 = l (left), tap 1 = r.
  task automatic beat(input logic [PW-1:0] l, input logic [PW-1:0] r);
    logic [PW-1:0] px;
    iDE   = 1'b1;
    iDATA = {r, l};
    tick();
    for (int k = 0; k < TP; k++) begin
      px = (k == 0) ? l : r;
      if (m_col + k < LW) begin
        m_bin[m_col + k] = (px < iTHRESHOLD);
        for (int p = 0; p < PL; p++) m_plane[p*LW + m_col + k] = px[PW-1-p];
      end
    end
    m_col = (m_col + TP > LW) ? LW : m_col + TP;
  endtask

  task automatic end_line;
    iDE = 1'b0;
    tick();
  endtask

  task automatic new_frame;
    iVSYNC = 1'b0;
    tick();
    iVSYNC = 1'b1;
    tick();
  endtask

  initial begin
    RST        = 1'b1;
    iVSYNC     = 1'b0;
    iDE        = 1'b0;
    iDATA      = '0;
    iTHRESHOLD = 8'h80;
    iMEM_SEL   = 1'b0;
    tick();
    tick();

    // ---- reset state
    chk("rst_we_a", oWE_A, 0);
    chk("rst_we_b", oWE_B, 0);
    chk("rst_row", oROW, 0);
    chk("rst_ovf", oOVERFLOW, 0);
    chk_w("rst_bin", oBIN_LINE, '0);
    chk_w("rst_plane", oPLANE_LINE, '0);
    RST = 1'b0;
    tick();

    // ---- test 1: alternating dark/bright full line into bank A, row 0
    iVSYNC = 1'b1;
    tick();
    model_start();
    beat(8'h10, 8'hF0);
    chk("t1_first_beat_bin", oBIN_LINE[1:0], 2'b01);
    for (int i = 1; i < 320; i++) beat(8'h10, 8'hF0);
    end_line();
    exp_bin = {320{2'b01}};
    exp_p0  = {320{2'b10}};
    chk_w("t1_bin_pattern", oBIN_LINE, exp_bin);
    chk_w("t1_plane0", oPLANE_LINE[LW-1:0], exp_p0);
    chk_w("t1_plane3_ones", oPLANE_LINE[3*LW +: LW], {LW{1'b1}});
    chk_w("t1_plane4_zero", oPLANE_LINE[4*LW +: LW], '0);
    chk_w("t1_planes_model", oPLANE_LINE, m_plane);
    chk("t1_we_a", oWE_A, 1);
    chk("t1_we_b", oWE_B, 0);
    chk("t1_row", oROW, 0);
    chk("t1_ovf", oOVERFLOW, 0);
    tick();
    chk("t1_we_a_drop", oWE_A, 0);
    chk("t1_next_row", oROW, 1);

    // ---- test 2: bank select latched at line start
    iMEM_SEL = 1'b0;
    model_start();
    for (int i = 0; i < 5; i++) beat(8'h00, 8'hFF);
    iMEM_SEL = 1'b1;
    for (int i = 0; i < 5; i++) beat(8'h00, 8'hFF);
    end_line();
    chk("t2_we_a", oWE_A, 1);
    chk("t2_we_b", oWE_B, 0);
    chk("t2_row", oROW, 1);
    chk_w("t2_bin", oBIN_LINE, m_bin);
    tick();
    model_start();
    for (int i = 0; i < 4; i++) beat(8'h00, 8'hFF);
    end_line();
    chk("t2b_we_a", oWE_A, 0);
    chk("t2b_we_b", oWE_B, 1);
    chk("t2b_row", oROW, 2);
    tick();

    // ---- test 3: 330-beat dark line overflows the column range
    iMEM_SEL = 1'b0;
    model_start();
    for (int i = 0; i < 320; i++) beat(8'h00, 8'h00);
    chk("t3_no_ovf_at_640", oOVERFLOW, 0);
    beat(8'h00, 8'h00);
    chk("t3_ovf_at_641", oOVERFLOW, 1);
    for (int i = 0; i < 9; i++) beat(8'h00, 8'h00);
    end_line();
    chk_w("t3_bin_all_dark", oBIN_LINE, {LW{1'b1}});
    chk("t3_we_a", oWE_A, 1);
    chk("t3_row", oROW, 3);
`ifdef CL_DARK_COUNT_EN
    chk("t3_dark_count", oDARK_COUNT, 640);
`endif
    tick();

    // ---- test 4: short line after a full dark line
    model_start();
    for (int i = 0; i < 10; i++) beat(8'h90, 8'h05);
    end_line();
    chk("t4_bin_lo", oBIN_LINE[19:0], 20'hAAAAA);
    chk_w("t4_bin_hi_zero", oBIN_LINE >> 20, '0);
    for (int p = 0; p < PL; p++)
      chk_w("t4_plane_hi_zero", oPLANE_LINE[p*LW +: LW] >> 20, '0);
    chk_w("t4_planes_model", oPLANE_LINE, m_plane);
    chk("t4_ovf_sticky", oOVERFLOW, 1);
    chk("t4_row", oROW, 4);
    tick();

    // New frame clears the overflow and the row.
    new_frame();
    chk("t3_ovf_cleared", oOVERFLOW, 0);
    chk("t3_row_cleared", oROW, 0);

    // ---- test 5: VSYNC falls mid-line
    model_start();
    for (int i = 0; i < 3; i++) beat(8'h00, 8'h00);
    end_line();
    chk("t5_pre_commit", oWE_A, 1);
    tick();
    chk("t5_pre_row", oROW, 1);
    model_start();
    for (int i = 0; i < 100; i++) beat(8'h00, 8'h00);
    iVSYNC = 1'b0;
    tick();
    iDE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_strobe", {oWE_A, oWE_B}, 2'b00);
      tick();
    end
    iVSYNC = 1'b1;
    tick();
    chk("t5_frame_row", oROW, 0);
    model_start();
    for (int i = 0; i < 3; i++) beat(8'h00, 8'h00);
    end_line();
    chk("t5_commit_we", oWE_A, 1);
    chk("t5_commit_row", oROW, 0);
    tick();

    // ---- test 6: asynchronous reset during capture
    model_start();
    for (int i = 0; i < 50; i++) beat(8'h00, 8'h00);
    #2;
    RST = 1'b1;
    #1;
    chk("t6_rst_we", {oWE_A, oWE_B}, 2'b00);
    chk("t6_rst_row", oROW, 0);
    chk_w("t6_rst_bin", oBIN_LINE, '0);
    chk_w("t6_rst_plane", oPLANE_LINE, '0);
    iDE = 1'b0;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_strobe", {oWE_A, oWE_B}, 2'b00);
    end
    new_frame();
    model_start();
    for (int i = 0; i < 320; i++) beat(8'h10, 8'hF0);
    end_line();
    chk("t6_line_we", oWE_A, 1);
    chk("t6_line_row", oROW, 0);
    chk_w("t6_line_bin", oBIN_LINE, exp_bin);
`ifdef CL_DARK_COUNT_EN
    chk("t6_dark_count", oDARK_COUNT, 320);
`endif
    tick();

    // ---- test 7: one-beat DE pulses up to row saturation
    new_frame();
    for (int i = 0; i < 2048; i++) begin
      iDE   = 1'b1;
      iDATA = {8'hFF, 8'h00};
      tick();
      if (i == 0) chk("t7_pulse_bin", oBIN_LINE[1:0], 2'b01);
      iDE = 1'b0;
      tick();
      if (i == 0 || i == 2047) begin
        chk("t7_strobe", oWE_A, 1);
        chk("t7_row", oROW, i);
        chk("t7_ovf_before", oOVERFLOW, 0);
      end
      tick();
    end
    chk("t7_row_hold", oROW, 2047);
    chk("t7_ovf_row", oOVERFLOW, 1);
    iDE = 1'b1;
    tick();
    iDE = 1'b0;
    tick();
    chk("t7_no_strobe_past_max", {oWE_A, oWE_B}, 2'b00);
    chk("t7_row_still_max", oROW, 2047);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cl_line_packer

// File: doc/cl_line_packer.md
Name: cl_line_packer

Overview:
Parametrised Camera Link line-capture block and successor to the fixed 2-tap capture logic.
- Accepts TAPS pixels per clock.
- Builds one dark-pixel binary line plus PLANES MSB bit-plane lines per video row.
- Commits each finished row to one of two line-memory banks with a single-cycle write strobe.
- Sits between the Camera Link deserialiser and the ping-pong line RAMs feeding pupil detection and VGA out.

Parameters:
PIXEL_WIDTH, 8, bits per pixel per tap
TAPS, 2, pixels delivered per clock (1, 2, 4 or 8; must divide LINE_WIDTH)
LINE_WIDTH, 640, pixels per memory line
ADDR_WIDTH, 11, row address width
PLANES, 5, MSB bit-planes captured (1..PIXEL_WIDTH)

Ports:
CCLK  in  1  pixel clock
RST  in  1  asynchronous active-high reset
iVSYNC  in  1  frame valid
iDE  in  1  line valid
iDATA  in  TAPS*PIXEL_WIDTH  pixels; tap k at bits [k*PIXEL_WIDTH +: PIXEL_WIDTH], tap 0 = leftmost
iTHRESHOLD  in  PIXEL_WIDTH  dark threshold
iMEM_SEL  in  1  bank select: 0 = A, 1 = B
oWE_A  out  1  one-cycle commit strobe, bank A
oWE_B  out  1  one-cycle commit strobe, bank B
oROW  out  ADDR_WIDTH  row being captured/committed
oBIN_LINE  out  LINE_WIDTH  bit c = 1 if pixel c < iTHRESHOLD
oPLANE_LINE  out  PLANES*LINE_WIDTH  plane p (0 = pixel MSB) at [p*LINE_WIDTH +: LINE_WIDTH]
oOVERFLOW  out  1  sticky per frame: pixel beyond LINE_WIDTH or row beyond 2^ADDR_WIDTH-1

Behaviour:
- Reset: all outputs 0; state IDLE; col = 0; internal iDE/iVSYNC delay registers = 0.
- Edge detection: each input is compared with its one-cycle registered copy. Rise = cur 1, prev 0. Fall = cur 0, prev 1.
- FSM states: IDLE, WAIT_LINE, CAPTURE, COMMIT.
- IDLE:
  - On VSYNC rise: row = 0, oOVERFLOW = 0, go to WAIT_LINE.
- WAIT_LINE:
  - On DE rise with iVSYNC = 1: latch iMEM_SEL into a bank register, clear oBIN_LINE and oPLANE_LINE to 0, col = 0, capture the first beat in the same cycle, go to CAPTURE.
  - The bank is fixed for the whole line; iMEM_SEL changes mid-line have no effect.
- CAPTURE, each cycle with iDE = 1:
  - For tap k, the destination column is col+k.
  - If col+k < LINE_WIDTH, write BIN[col+k] = (tap < iTHRESHOLD). Comparison is unsigned.
  - Also write plane p bit = tap[PIXEL_WIDTH-1-p].
  - If col+k >= LINE_WIDTH, drop the pixel and set oOVERFLOW.
  - col += TAPS, saturating at LINE_WIDTH.
  - Latency: a pixel sampled at edge n is visible on the outputs after edge n.
- CAPTURE, on DE fall: go to COMMIT.
  - During the COMMIT cycle, exactly one of oWE_A/oWE_B = 1, per the latched bank.
  - oROW holds the line's row; line outputs are stable.
- COMMIT, next edge:
  - Strobe drops.
  - row += 1, except when row = 2^ADDR_WIDTH-1: row holds and oOVERFLOW is set.
  - A committed line at the maximum row is still written; further lines are captured but not strobed.
  - Go to WAIT_LINE.
- Short lines: unwritten columns stay 0 from the line-start clear.
- VSYNC fall in any state: go to IDLE; a line in CAPTURE is aborted with no strobe. If COMMIT is active, it completes first.
- VSYNC rise in CAPTURE: abort the line (no strobe), row = 0, clear oOVERFLOW, go to WAIT_LINE.
- VSYNC rise and DE rise in the same cycle: row = 0 and line start both take effect.
- DE rise while iVSYNC = 0: ignored.
- DE pulse of 1 cycle: captures one beat and commits normally.
- Async RST mid-line: everything cleared immediately; no strobe.
- oWE_A and oWE_B are never both 1.

Optional Feature:
- Macro: CL_DARK_COUNT_EN.
- Defined:
  - Adds output oDARK_COUNT, width $clog2(LINE_WIDTH+1).
  - The register is cleared at line start and adds the dark-tap count each capture beat, counting in-range pixels only.
  - Valid and stable during the COMMIT cycle; holds until the next line start; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package cl_pkg holds:
  - FSM state enum (IDLE, WAIT_LINE, CAPTURE, COMMIT).
  - Default PIXEL_WIDTH and LINE_WIDTH.
  - Bank encoding constants.
- One natural sub-module: cl_edge_det, a registered rise/fall detector. Instantiate it twice, for iDE and iVSYNC.

Test Plan:
1. TAPS=2, threshold 0x80, VSYNC rise, then 320 beats with L = 0x10, R = 0xF0 -> BIN = alternating 1,0 from column 0. Plane 0 = 0,1 pattern. oWE_A pulses 1 cycle after DE fall with oROW = 0. Next line is at oROW = 1.
2. iMEM_SEL toggled 0 -> 1 mid-line -> that line strobes oWE_A only; the next line strobes oWE_B.
3. Line of 330 beats with TAPS=2 -> columns 0..639 written, oOVERFLOW = 1. Next VSYNC rise clears it.
4. Line of 10 beats after a full dark line -> columns 20..639 read 0 in BIN and all planes.
5. VSYNC falls at beat 100 of a line -> no strobe. Next frame starts at oROW = 0.
6. RST pulsed during CAPTURE -> all outputs 0 immediately, no strobe. With CL_DARK_COUNT_EN, the next full line of the pattern in test 1 gives oDARK_COUNT = 320.
